// File: rtl/icache_responder.sv
// Direct-mapped instruction cache: zero-latency hit path, single-outstanding
// miss fetch from memory control, saturating hit/miss counters.

module icache_frame #(
  parameter int TAGW = 26
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            inv,
  input  logic            we,
  input  logic [TAGW-1:0] wtag,
  input  logic [31:0]     wdata,
  output logic            vld,
  output logic [TAGW-1:0] tag,
  output logic [31:0]     data
);
  // invalidate outranks a same-cycle fill so the frame stays empty
  always_ff @(posedge CLK) begin
    if (RST || inv) vld <= 1'b0;
    else if (we)    vld <= 1'b1;
  end

  always_ff @(posedge CLK) begin
    if (we) begin
      tag  <= wtag;
      data <= wdata;
    end
  end
endmodule

module icache_responder #(
  parameter int NFRAMES = 16,
  localparam int IDXW   = $clog2(NFRAMES),
  localparam int TAGW   = 30 - IDXW
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        imemREN,
  input  logic [31:0] imemaddr,
  output logic        ihit,
  output logic [31:0] imemload,
  output logic        iREN,
  output logic [31:0] iaddr,
  input  logic        iwait,
  input  logic [31:0] iload,
  input  logic        invalidate,
  output logic [31:0] hit_count,
  output logic [31:0] miss_count
);
  typedef struct packed {
    logic [TAGW-1:0] tag;
    logic [IDXW-1:0] idx;
  } waddr_t;

  typedef enum logic {IDLE, FETCH} state_t;

  state_t state, state_nxt;

  waddr_t req, miss_req;
  logic [31:0] missaddr;

  logic [NFRAMES-1:0]           frame_vld;
  logic [NFRAMES-1:0][TAGW-1:0] frame_tag;
  logic [NFRAMES-1:0][31:0]     frame_data;

  logic hit_raw, fill_we, miss_evt;

  assign req      = imemaddr[31:2];
  assign miss_req = missaddr[31:2];

  // fills always target the latched miss address, never the live request
  for (genvar g = 0; g < NFRAMES; g++) begin : g_frame
    icache_frame #(.TAGW(TAGW)) u_frame (
      .CLK   (CLK),
      .RST   (RST),
      .inv   (invalidate),
      .we    (fill_we && (miss_req.idx == IDXW'(g))),
      .wtag  (miss_req.tag),
      .wdata (iload),
      .vld   (frame_vld[g]),
      .tag   (frame_tag[g]),
      .data  (frame_data[g])
    );
  end

  assign hit_raw  = frame_vld[req.idx] && (frame_tag[req.idx] == req.tag);
  assign miss_evt = (state == IDLE) && imemREN && !ihit;

  always_ff @(posedge CLK) begin
    if (RST) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (miss_evt) state_nxt = FETCH;
      FETCH:   if (!iwait)   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    ihit     = 1'b0;
    imemload = '0;
    iREN     = 1'b0;
    iaddr    = '0;
    fill_we  = 1'b0;
    case (state)
      IDLE: begin
        ihit = imemREN && hit_raw && !invalidate;
        if (ihit) imemload = frame_data[req.idx];
      end
      FETCH: begin
        iREN    = 1'b1;
        iaddr   = missaddr;
        fill_we = !iwait;
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST)           missaddr <= '0;
    else if (miss_evt) missaddr <= imemaddr;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      hit_count  <= '0;
      miss_count <= '0;
    end else begin
      if (ihit && (hit_count != '1))      hit_count  <= hit_count + 32'd1;
      if (miss_evt && (miss_count != '1)) miss_count <= miss_count + 32'd1;
    end
  end
endmodule

// File: tb/tb_icache_responder.sv
// Directed bench for icache_responder: per-cycle vector table plus
// hand sequences for reset mid-fetch, invalidate in IDLE and saturation.

module tb_icache_responder;
  logic        CLK = 1'b0;
  logic        RST;
  logic        imemREN;
  logic [31:0] imemaddr;
  logic        ihit;
  logic [31:0] imemload;
  logic        iREN;
  logic [31:0] iaddr;
  logic        iwait;
  logic [31:0] iload;
  logic        invalidate;
  logic [31:0] hit_count;
  logic [31:0] miss_count;

  int n_chk  = 0;
  int n_pass = 0;

  icache_responder #(.NFRAMES(16)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .imemREN    (imemREN),
    .imemaddr   (imemaddr),
    .ihit       (ihit),
    .imemload   (imemload),
    .iREN       (iREN),
    .iaddr      (iaddr),
    .iwait      (iwait),
    .iload      (iload),
    .invalidate (invalidate),
    .hit_count  (hit_count),
    .miss_count (miss_count)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic        ren;
    logic [31:0] addr;
    logic        iw;
    logic [31:0] ld;
    logic        inv;
    logic        e_hit;
    logic [31:0] e_load;
    logic        e_iren;
    logic [31:0] e_iaddr;
    logic [31:0] e_hits;
    logic [31:0] e_miss;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s [%0d]: got %h want %h", name, idx, act, exp);
  endtask

  task automatic drive(input logic ren, input logic [31:0] addr, input logic iw,
                       input logic [31:0] ld, input logic inv);
    imemREN = ren; imemaddr = addr; iwait = iw; iload = ld; invalidate = inv;
  endtask

  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  function automatic vec_t mk(logic ren, logic [31:0] addr, logic iw, logic [31:0] ld, logic inv,
                              logic e_hit, logic [31:0] e_load, logic e_iren, logic [31:0] e_iaddr,
                              logic [31:0] e_hits, logic [31:0] e_miss);
    vec_t v;
    v.ren = ren; v.addr = addr; v.iw = iw; v.ld = ld; v.inv = inv;
    v.e_hit = e_hit; v.e_load = e_load; v.e_iren = e_iren; v.e_iaddr = e_iaddr;
    v.e_hits = e_hits; v.e_miss = e_miss;
    return v;
  endfunction

  initial begin
    // cold miss, latency 3
    vecs.push_back(mk(1, 32'h40,  1, 0,            0, 0, 0,            0, 0,      0, 0));
    vecs.push_back(mk(1, 32'h40,  1, 0,            0, 0, 0,            1, 32'h40, 0, 1));
    vecs.push_back(mk(1, 32'h40,  1, 0,            0, 0, 0,            1, 32'h40, 0, 1));
    vecs.push_back(mk(1, 32'h40,  0, 32'h24020005, 0, 0, 0,            1, 32'h40, 0, 1));
    vecs.push_back(mk(1, 32'h40,  1, 0,            0, 1, 32'h24020005, 0, 0,      0, 1));
    vecs.push_back(mk(0, 32'h40,  1, 0,            0, 0, 0,            0, 0,      1, 1));
    // conflict eviction on index 0
    vecs.push_back(mk(1, 32'h80,  1, 0,            0, 0, 0,            0, 0,      1, 1));
    vecs.push_back(mk(1, 32'h80,  0, 32'hAAAA0080, 0, 0, 0,            1, 32'h80, 1, 2));
    vecs.push_back(mk(1, 32'h80,  1, 0,            0, 1, 32'hAAAA0080, 0, 0,      1, 2));
    vecs.push_back(mk(1, 32'h40,  1, 0,            0, 0, 0,            0, 0,      2, 2));
    vecs.push_back(mk(1, 32'h40,  0, 32'h24020005, 0, 0, 0,            1, 32'h40, 2, 3));
    vecs.push_back(mk(1, 32'h40,  1, 0,            0, 1, 32'h24020005, 0, 0,      2, 3));
    vecs.push_back(mk(0, 32'h0,   1, 0,            0, 0, 0,            0, 0,      3, 3));
    // redirect during fetch
    vecs.push_back(mk(1, 32'h100, 1, 0,            0, 0, 0,            0, 0,       3, 3));
    vecs.push_back(mk(1, 32'h200, 1, 0,            0, 0, 0,            1, 32'h100, 3, 4));
    vecs.push_back(mk(0, 32'h200, 1, 0,            0, 0, 0,            1, 32'h100, 3, 4));
    vecs.push_back(mk(1, 32'h200, 0, 32'h11110100, 0, 0, 0,            1, 32'h100, 3, 4));
    vecs.push_back(mk(1, 32'h100, 1, 0,            0, 1, 32'h11110100, 0, 0,       3, 4));
    vecs.push_back(mk(1, 32'h200, 1, 0,            0, 0, 0,            0, 0,       4, 4));
    vecs.push_back(mk(1, 32'h200, 0, 32'h22220200, 0, 0, 0,            1, 32'h200, 4, 5));
    vecs.push_back(mk(0, 32'h0,   1, 0,            0, 0, 0,            0, 0,       4, 5));
    // invalidate coinciding with fill completion
    vecs.push_back(mk(1, 32'h44,  1, 0,            0, 0, 0,            0, 0,      4, 5));
    vecs.push_back(mk(1, 32'h44,  0, 32'h33330044, 1, 0, 0,            1, 32'h44, 4, 6));
    vecs.push_back(mk(1, 32'h44,  1, 0,            0, 0, 0,            0, 0,      4, 6));
    vecs.push_back(mk(1, 32'h44,  0, 32'h33330044, 0, 0, 0,            1, 32'h44, 4, 7));
    vecs.push_back(mk(1, 32'h44,  1, 0,            0, 1, 32'h33330044, 0, 0,      4, 7));
    vecs.push_back(mk(0, 32'h0,   1, 0,            0, 0, 0,            0, 0,      5, 7));

    RST = 1'b1;
    drive(0, 0, 1, 0, 0);
    cyc();
    RST = 1'b0;
    chk("rst_ihit", 0, 32'(ihit), 0);
    chk("rst_iren", 0, 32'(iREN), 0);
    chk("rst_iaddr", 0, iaddr, 0);
    chk("rst_load", 0, imemload, 0);
    chk("rst_hits", 0, hit_count, 0);
    chk("rst_miss", 0, miss_count, 0);

    foreach (vecs[i]) begin
      drive(vecs[i].ren, vecs[i].addr, vecs[i].iw, vecs[i].ld, vecs[i].inv);
      #3;
      chk("ihit", i, 32'(ihit), 32'(vecs[i].e_hit));
      chk("imemload", i, imemload, vecs[i].e_load);
      chk("iREN", i, 32'(iREN), 32'(vecs[i].e_iren));
      chk("iaddr", i, iaddr, vecs[i].e_iaddr);
      chk("hit_count", i, hit_count, vecs[i].e_hits);
      chk("miss_count", i, miss_count, vecs[i].e_miss);
      cyc();
    end

    // invalidate in IDLE masks an otherwise valid hit on 0x44
    drive(1, 32'h44, 1, 0, 1);
    #3;
    chk("inv_idle_ihit", 0, 32'(ihit), 0);
    chk("inv_idle_load", 0, imemload, 0);
    RST = 1'b1;
    cyc();
    RST = 1'b0;
    drive(0, 0, 1, 0, 0);
    #1;
    chk("rst2_iren", 0, 32'(iREN), 0);
    chk("rst2_hits", 0, hit_count, 0);

    // reset mid-fetch: fill 0x40, then abort a fetch of 0x80
    drive(1, 32'h40, 1, 0, 0); cyc();
    drive(1, 32'h40, 0, 32'h24020005, 0); cyc();
    drive(1, 32'h40, 1, 0, 0);
    #1;
    chk("mf_prefill_hit", 0, 32'(ihit), 1);
    cyc();
    drive(1, 32'h80, 1, 0, 0); cyc();
    #1;
    chk("mf_fetch_iren", 0, 32'(iREN), 1);
    chk("mf_fetch_iaddr", 0, iaddr, 32'h80);
    RST = 1'b1;
    cyc();
    RST = 1'b0;
    drive(0, 32'h80, 1, 0, 0);
    #1;
    chk("mf_iren", 0, 32'(iREN), 0);
    chk("mf_iaddr", 0, iaddr, 0);
    chk("mf_hits", 0, hit_count, 0);
    chk("mf_miss", 0, miss_count, 0);
    drive(1, 32'h40, 1, 0, 0);
    #1;
    chk("mf_prior_miss", 0, 32'(ihit), 0);
    cyc();
    #1;
    chk("mf_refetch_iren", 0, 32'(iREN), 1);
    chk("mf_miss_after", 0, miss_count, 1);

    // complete that refetch, then saturate hit_count
    drive(1, 32'h40, 0, 32'h24020005, 0); cyc();
    drive(0, 32'h40, 1, 0, 0);
    force dut.hit_count = 32'hFFFF_FFFE;
    #1;
    release dut.hit_count;
    cyc();
    for (int k = 0; k < 3; k++) begin
      drive(1, 32'h40, 1, 0, 0);
      #1;
      chk("sat_ihit", k, 32'(ihit), 1);
      cyc();
      chk("sat_hits", k, hit_count, 32'hFFFF_FFFF);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
